// File: rtl/uart_tx_param_if.sv
// Write-side port of the UART transmitter: enqueue strobe/data toward the TX FIFO and
// FIFO status back to the producer.
interface uart_tx_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             d_ready;
  logic [WIDTH-1:0] d_in;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output d_ready, d_in,
    input  fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  d_ready, d_in,
    output fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_param.sv
// UART transmitter with a DEPTH-entry TX FIFO; a pop launches a frame one edge after the word lands.
// Writes into a full FIFO are dropped with a one-cycle overflow pulse; frames never abort except on reset.
module uart_tx_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [1:0]            parity_mode,
  uart_tx_param_if.slave        wr,
  output logic                  tx_data,
  output logic                  busy
);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(WIDTH - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;

  logic             full, empty, wr_acc, pop, bit_end, can_start;
  logic [WIDTH-1:0] head;

  // Status comes from registered occupancy only, so a same-edge pop never frees a slot for a write.
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    wr_acc    = wr.d_ready && !full;
    ovf_d     = wr.d_ready && full;
    head      = mem_q[rd_ptr_q];
    bit_end   = (baud_q == BAUD_LAST);
    can_start = en && !empty;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (can_start) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Parity mode is captured with the word so later changes cannot disturb this frame.
    if (pop) begin
      shreg_d   = head;
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (^head) ^ (parity_mode == 2'b10);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr.d_in;
  end

  always_comb begin
    case (state_q)
      S_START:  tx_data = 1'b0;
      S_DATA:   tx_data = shreg_q[0];
      S_PARITY: tx_data = par_bit_q;
      default:  tx_data = 1'b1;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign wr.fifo_full  = full;
  assign wr.fifo_empty = empty;
  assign wr.fifo_count = count_q;
  assign wr.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: frame-level reference model checked every cycle, directed literal
// scenarios, a STOP_BITS=2 instance, then randomized traffic with occasional resets.
module tb_uart_tx_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CLKS  = 4;
  localparam int STOPB = 1;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b0;
  logic [1:0] pm   = 2'b00;
  logic       tx, busy;
  logic       en2  = 1'b0;
  logic [1:0] pm2  = 2'b00;
  logic       tx2, busy2;

  int checks = 0;
  int errors = 0;

  uart_tx_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) wr_if ();
  uart_tx_param_if #(.WIDTH(8), .DEPTH(4)) wr2_if ();

  uart_tx_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLKS_PER_BIT(CLKS), .STOP_BITS(STOPB)) dut (
    .clk(clk), .rstn(rstn), .en(en), .parity_mode(pm), .wr(wr_if), .tx_data(tx), .busy(busy));

  uart_tx_param #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .parity_mode(pm2), .wr(wr2_if), .tx_data(tx2), .busy(busy2));

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, each frame as an explicit bit list indexed by elapsed cycles.
  logic [WIDTH-1:0] mq[$];
  bit               m_act  = 1'b0;
  int               m_pos  = 0;
  int               m_len  = 0;
  logic [15:0]      m_bits = '1;
  logic             m_ovf  = 1'b0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      mq.delete();
      m_act = 1'b0; m_pos = 0; m_ovf = 1'b0;
    end else begin
      int  pre;
      bit  start;
      pre   = mq.size();
      start = en && (pre != 0) && (!m_act || m_pos == m_len - 1);
      m_ovf = wr_if.d_ready && (pre == DEPTH);
      if (start) begin
        logic [WIDTH-1:0] w;
        int n;
        w = mq.pop_front();
        m_bits = '1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_bits[1+i] = w[i];
        n = 1 + WIDTH;
        if (pm == 2'b01 || pm == 2'b10) begin
          m_bits[n] = (^w) ^ (pm == 2'b10);
          n++;
        end
        n = n + STOPB;
        m_len = n * CLKS;
        m_pos = 0;
        m_act = 1'b1;
      end else if (m_act) begin
        m_pos++;
        if (m_pos == m_len) m_act = 1'b0;
      end
      if (wr_if.d_ready && pre < DEPTH) mq.push_back(wr_if.d_in);
    end
  end

  initial forever begin
    logic [7:0] exp_v, act_v;
    @(negedge clk);
    exp_v = {(m_act ? m_bits[m_pos/CLKS] : 1'b1), m_act, (mq.size() == DEPTH),
             (mq.size() == 0), m_ovf, 3'(mq.size())};
    act_v = {tx, busy, wr_if.fifo_full, wr_if.fifo_empty, wr_if.overflow, wr_if.fifo_count};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t actual %b required %b (tx busy full empty ovf cnt)",
               $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] v);
    wr_if.d_ready = 1'b1;
    wr_if.d_in    = v;
    tick();
    wr_if.d_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  // Called just after a pop edge: measures how long busy stays high and samples each bit mid-cell.
  task automatic run_frame(output int len, output logic [15:0] cap);
    len = 0;
    cap = '1;
    while (busy && len < 400) begin
      if (len % CLKS == 1 && len / CLKS < 16) cap[len/CLKS] = tx;
      len++;
      tick();
    end
    chk("frame_bounded", int'(len < 400), 1);
  endtask

  initial begin
    int          len, ones, n;
    logic [15:0] cap;
    logic [47:0] line2;
    wr_if.d_ready  = 1'b0; wr_if.d_in  = '0;
    wr2_if.d_ready = 1'b0; wr2_if.d_in = '0;
    rstn = 1'b0;
    tick(); tick(); tick();
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(wr_if.fifo_empty), 1);
    chk("rst_full", int'(wr_if.fifo_full), 0);
    chk("rst_count", int'(wr_if.fifo_count), 0);
    chk("rst_ovf", int'(wr_if.overflow), 0);
    rstn = 1'b1;
    tick();

    // Two stop bits: stop-high window of 8 cycles, then the queued word starts at once.
    en2 = 1'b1;
    wr2_if.d_ready = 1'b1; wr2_if.d_in = 8'hFF; tick();
    wr2_if.d_in = 8'h3C; tick();
    wr2_if.d_ready = 1'b0;
    for (int i = 0; i < 48; i++) begin
      line2[i] = tx2;
      if (i == 44) chk("stop2_busy_gapless", int'(busy2), 1);
      tick();
    end
    ones = 0;
    for (int i = 36; i < 44; i++) ones += int'(line2[i]);
    chk("stop2_start", int'(line2[0]), 0);
    chk("stop2_high_cycles", ones, 8);
    chk("stop2_next_start", int'(line2[44]), 0);
    n = 0;
    while (busy2 && n < 100) begin n++; tick(); end
    chk("stop2_drain", int'(busy2), 0);
    en2 = 1'b0;

    // 0xA5, no parity.
    en = 1'b1; pm = 2'b00;
    put(8'hA5);
    tick();
    chk("a5_start_tx", int'(tx), 0);
    chk("a5_busy", int'(busy), 1);
    run_frame(len, cap);
    chk("a5_len", len, 40);
    chk("a5_bits", int'(cap[9:0]), int'(10'b1101001010));
    chk("a5_idle_tx", int'(tx), 1);

    // 0x07 even then odd parity; parity_mode changes after the pop must not matter.
    pm = 2'b01;
    put(8'h07);
    tick();
    pm = 2'b00;
    run_frame(len, cap);
    chk("even_len", len, 44);
    chk("even_bits", int'(cap[10:0]), int'(11'b11000001110));
    pm = 2'b10;
    put(8'h07);
    tick();
    pm = 2'b11;
    run_frame(len, cap);
    chk("odd_len", len, 44);
    chk("odd_parity", int'(cap[9]), 0);

    // Fill while disabled, overflow on the fifth write, then gapless drain.
    en = 1'b0; pm = 2'b00;
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    chk("fill_full", int'(wr_if.fifo_full), 1);
    put(8'h05);
    chk("fill_ovf_pulse", int'(wr_if.overflow), 1);
    tick();
    chk("fill_ovf_clear", int'(wr_if.overflow), 0);
    chk("fill_count", int'(wr_if.fifo_count), 4);
    chk("fill_tx_idle", int'(tx), 1);
    en = 1'b1;
    tick();
    chk("drain_count_after_pop", int'(wr_if.fifo_count), 3);
    run_frame(len, cap);
    chk("drain_len", len, 160);
    chk("drain_first_bits", int'(cap[9:0]), int'(10'b1000000010));
    chk("drain_empty", int'(wr_if.fifo_empty), 1);

    // Drop en during data bit 3 with a second word queued.
    en = 1'b0;
    put(8'h11); put(8'h22);
    en = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) tick();
    en = 1'b0;
    run_frame(len, cap);
    chk("endrop_len", len + 17, 40);
    chk("endrop_count", int'(wr_if.fifo_count), 1);
    chk("endrop_busy", int'(busy), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("endrop_stays_idle", int'(busy), 0);

    // Reset in the middle of DATA with three words queued.
    do_reset();
    en = 1'b0;
    put(8'h5A); put(8'hC3); put(8'h81);
    en = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    rstn = 1'b0;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(wr_if.fifo_count), 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("midrst_no_frame", int'(busy), 0);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      wr_if.d_ready = ($urandom_range(0, 9) < 2);
      wr_if.d_in    = 8'($urandom);
      pm            = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
      tick();
    end
    wr_if.d_ready = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter DEPTH, default 4: TX FIFO entries, power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 4: clk cycles per serial bit, at least 1.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 clk  in  1: single clock; all state changes on its rising edge.
REQ-006 rstn  in  1: reset, asynchronous and active-low.
REQ-007 en  in  1: transmit enable; new frames start only while high.
REQ-008 d_ready  in  1: write strobe; d_in is offered when high.
REQ-009 d_in  in  WIDTH: data word to enqueue.
REQ-010 parity_mode  in  2: 00 none, 01 even, 10 odd, 11 none; sampled at frame start.
REQ-011 tx_data  out  1: serial line, idle high.
REQ-012 busy  out  1: high whenever state is not IDLE.
REQ-013 fifo_full  out  1: FIFO holds DEPTH words.
REQ-014 fifo_empty  out  1: FIFO holds 0 words.
REQ-015 fifo_count  out  $clog2(DEPTH+1): FIFO occupancy.
REQ-016 overflow  out  1: one-cycle pulse when a write is dropped.

Function
REQ-017 A write is accepted on a rising edge where d_ready=1 and fifo_full=0; d_in is enqueued and fifo_count increments.
REQ-018 A write is dropped when d_ready=1 and fifo_full=0 is false; overflow is high for the next cycle only and the FIFO is unchanged.
REQ-019 fifo_full is evaluated before any same-cycle pop; a pop in the same cycle does not admit a write to a full FIFO.
REQ-020 There is no bypass path; a word written to an empty FIFO is popped no earlier than the following edge.
REQ-021 A simultaneous accepted write and pop leaves fifo_count unchanged.
REQ-022 Read and write pointers wrap modulo DEPTH.
REQ-023 The state machine has five states: IDLE, START, DATA, PARITY and STOP.
REQ-024 IDLE to START on an edge with en=1 and fifo_empty=0; that edge pops the head word into the shift register and latches parity_mode.
REQ-025 tx_data is low for the CLKS_PER_BIT cycles starting at the START entry edge.
REQ-026 DATA transmits WIDTH bits LSB first, each for CLKS_PER_BIT cycles.
REQ-027 PARITY is entered only when the latched mode is 01 or 10; otherwise DATA goes directly to STOP.
REQ-028 The parity bit is the XOR of the data bits for even mode and its inverse for odd mode.
REQ-029 STOP drives tx_data high for STOP_BITS*CLKS_PER_BIT cycles.
REQ-030 At the end of STOP, the block goes directly to START (gapless, with a pop) if en=1 and the FIFO is non-empty; otherwise it goes to IDLE.
REQ-031 Frame length is (1+WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
REQ-032 Deasserting en mid-frame does not abort the frame; the current frame completes and the block then stays in IDLE.
REQ-033 Writes are accepted regardless of en.
REQ-034 Changes to parity_mode mid-frame have no effect on the current frame.

Reset
REQ-035 While rstn=0: tx_data=1, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0; state IDLE; pointers and bit/baud counters cleared.
REQ-036 Reset mid-frame discards the frame in progress and all FIFO contents immediately.

Verification
REQ-037 Defaults, parity_mode=00, en=1, write 0xA5 -> from the pop edge, tx_data = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); busy falls after the stop bit.
REQ-038 parity_mode=01, write 0x07 -> parity bit 1; repeat with parity_mode=10 -> parity bit 0; frame is 44 cycles.
REQ-039 en=0, five writes 0x01..0x05 -> fifo_full after the 4th, 5th write raises a single overflow pulse, fifo_count=4, tx_data stays 1; then en=1 -> 0x01..0x04 are sent back-to-back with no idle cycle between frames.
REQ-040 STOP_BITS=2, write 0xFF -> stop-high period is 8 cycles; a second word queued is started immediately after it.
REQ-041 en dropped during bit 3 of a frame with 2 words queued -> the frame completes and the block enters IDLE with fifo_count=1 and busy=0.
REQ-042 rstn pulsed low during DATA with 3 words queued -> tx_data=1 asynchronously, fifo_count=0, and no further frame is sent after reset release.
